// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front end: select codes, flag bit
// positions and the issue controller state encoding.
package alu_pkg;

  localparam int SEL_W  = 3;
  localparam int FLAG_W = 5;

  // ALU select encodings
  localparam logic [SEL_W-1:0] SEL_ADD = 3'b000;
  localparam logic [SEL_W-1:0] SEL_SUB = 3'b001;
  localparam logic [SEL_W-1:0] SEL_AND = 3'b010;
  localparam logic [SEL_W-1:0] SEL_OR  = 3'b011;
  localparam logic [SEL_W-1:0] SEL_XOR = 3'b100;
  localparam logic [SEL_W-1:0] SEL_NOT = 3'b101;
  localparam logic [SEL_W-1:0] SEL_SHL = 3'b110;
  localparam logic [SEL_W-1:0] SEL_SHR = 3'b111;

  // Bit positions inside the ALU flags vector
  localparam int FLAG_SIGN  = 4;
  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_PAR   = 1;
  localparam int FLAG_CARRY = 0;

  // Issue controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command buffer for the ALU issue front end. First-word-fall-through
// synchronous FIFO: the head entry is visible on rdata_o whenever the FIFO
// is non-empty, and a pop simply advances past it.
module alu_cmd_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DW-1:0]                wdata_i,
  output logic [DW-1:0]                rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pushes into a full FIFO and pops from an empty one are ignored, so the
  // pointers can never overrun each other even with a careless caller.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential front end for an external combinational ALU. Buffers commands,
// drives registered operands/select onto the ALU, captures the result into a
// held response register, and keeps an accumulator of the last result that a
// command may substitute for its A operand.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [WIDTH-1:0]             cmd_a_i,
  input  logic [WIDTH-1:0]             cmd_b_i,
  input  logic [SEL_W-1:0]             cmd_sel_i,
  input  logic                         cmd_use_acc_i,
  output logic [WIDTH-1:0]             alu_a_o,
  output logic [WIDTH-1:0]             alu_b_o,
  output logic [SEL_W-1:0]             alu_sel_o,
  input  logic [WIDTH-1:0]             alu_y_i,
  input  logic [FLAG_W-1:0]            alu_flags_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [WIDTH-1:0]             rsp_y_o,
  output logic [FLAG_W-1:0]            rsp_flags_o,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count_o,
  output logic                         ovf_sticky_o,
  input  logic                         ovf_clr_i
);

  localparam int CMD_W = WIDTH + WIDTH + SEL_W + 1;

  issue_state_e state_q, state_d;

  logic [WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [WIDTH-1:0]  alu_b_q, alu_b_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0]  rsp_y_q, rsp_y_d;
  logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CMD_W-1:0]  fifo_wdata;
  logic [CMD_W-1:0]  fifo_rdata;

  logic [WIDTH-1:0]  head_a;
  logic [WIDTH-1:0]  head_b;
  logic [SEL_W-1:0]  head_sel;
  logic              head_use_acc;

  // Readiness depends only on occupancy, never on a same-cycle pop, so a
  // full FIFO refuses a push even in the cycle it is being drained.
  assign cmd_ready_o = !fifo_full;
  assign fifo_push   = cmd_valid_i && cmd_ready_o;
  assign fifo_wdata  = {cmd_a_i, cmd_b_i, cmd_sel_i, cmd_use_acc_i};
  assign {head_a, head_b, head_sel, head_use_acc} = fifo_rdata;

  alu_cmd_fifo #(
    .DW    (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  // Issue sequencing: pop and load operands, let the ALU settle for one
  // cycle, capture the result, then hold it until the consumer takes it.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    rsp_valid_d = rsp_valid_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          alu_a_d   = head_use_acc ? acc_q : head_a;
          alu_b_d   = head_b;
          alu_sel_d = head_sel;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rsp_y_d     = alu_y_i;
        rsp_flags_d = alu_flags_i;
        acc_d       = alu_y_i;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            alu_a_d   = head_use_acc ? acc_q : head_a;
            alu_b_d   = head_b;
            alu_sel_d = head_sel;
            state_d   = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A capture of an overflowing result outranks a simultaneous clear.
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if ((state_q == ST_ISSUE) && alu_flags_i[FLAG_OVF]) begin
      ovf_d = 1'b1;
    end
  end

  // State, operand, response and accumulator registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      rsp_valid_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_valid_q <= rsp_valid_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_sel_o    = alu_sel_q;
  assign rsp_y_o      = rsp_y_q;
  assign rsp_flags_o  = rsp_flags_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign ovf_sticky_o = ovf_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural ALU attached. Accepted commands
// are turned into expected responses by an integer-arithmetic model; a
// monitor compares every consumed response against that queue in order.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct {
    logic [3:0] y;
    logic [4:0] f;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_a;
  logic [3:0]    cmd_b;
  logic [2:0]    cmd_sel;
  logic          cmd_use_acc;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [2:0]    alu_sel;
  logic [3:0]    alu_y;
  logic [4:0]    alu_flags;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [3:0]    rsp_y;
  logic [4:0]    rsp_flags;
  logic [CW-1:0] fifo_count;
  logic          ovf_sticky;
  logic          ovf_clr;

  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;
  exp_t expQ[$];
  int   rspCycles[$];
  logic [3:0] accModel;
  exp_t monE;
  logic [8:0] monR;
  logic [3:0] monA;
  logic [8:0] aluOut;

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  alu_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_a_i       (cmd_a),
    .cmd_b_i       (cmd_b),
    .cmd_sel_i     (cmd_sel),
    .cmd_use_acc_i (cmd_use_acc),
    .alu_a_o       (alu_a),
    .alu_b_o       (alu_b),
    .alu_sel_o     (alu_sel),
    .alu_y_i       (alu_y),
    .alu_flags_i   (alu_flags),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_y_o       (rsp_y),
    .rsp_flags_o   (rsp_flags),
    .fifo_count_o  (fifo_count),
    .ovf_sticky_o  (ovf_sticky),
    .ovf_clr_i     (ovf_clr)
  );

  // 4-bit ALU behaviour in plain integer arithmetic; returns {flags, y}.
  function automatic logic [8:0] aluRef(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] sel);
    int ai, bi, sa, sb, r, sr;
    logic [3:0] y;
    logic c, v;
    ai = int'(a);
    bi = int'(b);
    sa = (ai > 7) ? ai - 16 : ai;
    sb = (bi > 7) ? bi - 16 : bi;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    sr = 0;
    case (sel)
      SEL_ADD: begin r = ai + bi; sr = sa + sb; c = (r > 15); v = (sr > 7) || (sr < -8); end
      SEL_SUB: begin r = ai - bi; sr = sa - sb; c = (ai < bi); v = (sr > 7) || (sr < -8); end
      SEL_AND: r = int'(a & b);
      SEL_OR:  r = int'(a | b);
      SEL_XOR: r = int'(a ^ b);
      SEL_NOT: r = 15 - ai;
      SEL_SHL: begin r = ai * 2; c = (ai > 7); end
      SEL_SHR: begin r = ai / 2; c = (ai % 2 == 1); end
      default: r = 0;
    endcase
    y = 4'(r);
    return {y[3], (y == 4'd0), v, ^y, c, y};
  endfunction

  assign aluOut    = aluRef(alu_a, alu_b, alu_sel);
  assign alu_y     = aluOut[3:0];
  assign alu_flags = aluOut[8:4];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one command and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] sel, input logic useAcc);
    int n;
    cmd_a = a;
    cmd_b = b;
    cmd_sel = sel;
    cmd_use_acc = useAcc;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL push_timeout: got cmd_ready=0, expected acceptance within 50 cycles");
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Monitor: compare consumed responses, then record newly accepted commands.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_rsp: got y=%0d flags=%b, expected no response", rsp_y, rsp_flags);
        end else begin
          monE = expQ.pop_front();
          checkOutput("rsp_y", int'(rsp_y), int'(monE.y));
          checkOutput("rsp_flags", int'(rsp_flags), int'(monE.f));
          rspCycles.push_back(cycle);
        end
      end
      if (cmd_valid && cmd_ready) begin
        monA = cmd_use_acc ? accModel : cmd_a;
        monR = aluRef(monA, cmd_b, cmd_sel);
        accModel = monR[3:0];
        monE.y = monR[3:0];
        monE.f = monR[8:4];
        expQ.push_back(monE);
      end
    end
  end

  initial begin
    logic accepted;
    int n;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_sel = '0;
    cmd_use_acc = 1'b0;
    rsp_ready = 1'b0;
    ovf_clr = 1'b0;
    accModel = '0;

    // Reset values
    @(posedge clk);
    #1;
    checkOutput("rst_alu_a", int'(alu_a), 0);
    checkOutput("rst_alu_b", int'(alu_b), 0);
    checkOutput("rst_alu_sel", int'(alu_sel), 0);
    checkOutput("rst_rsp_y", int'(rsp_y), 0);
    checkOutput("rst_rsp_flags", int'(rsp_flags), 0);
    checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
    checkOutput("rst_ovf_sticky", int'(ovf_sticky), 0);
    checkOutput("rst_fifo_count", int'(fifo_count), 0);
    checkOutput("rst_cmd_ready", int'(cmd_ready), 1);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Single ADD 3+5: latency and overflow capture
    applyStimulus(4'd3, 4'd5, SEL_ADD, 1'b0);
    checkOutput("lat_after_accept", int'(rsp_valid), 0);
    step(1);
    checkOutput("lat_after_pop", int'(rsp_valid), 0);
    step(1);
    checkOutput("lat_after_issue", int'(rsp_valid), 1);
    checkOutput("add_y_direct", int'(rsp_y), 8);
    checkOutput("add_ovf_sticky", int'(ovf_sticky), 1);
    rsp_ready = 1'b1;
    step(2);

    // Sticky clear with no new overflow
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    checkOutput("ovf_clr", int'(ovf_sticky), 0);

    // Accumulator substitution: 8 - 8
    applyStimulus(4'd2, 4'd8, SEL_SUB, 1'b1);
    step(1);
    checkOutput("acc_alu_a", int'(alu_a), 8);
    checkOutput("acc_alu_sel", int'(alu_sel), int'(SEL_SUB));
    step(1);
    checkOutput("acc_sub_y", int'(rsp_y), 0);
    checkOutput("acc_sub_zero", int'(rsp_flags[FLAG_ZERO]), 1);
    step(2);
    checkOutput("ovf_still_clear", int'(ovf_sticky), 0);

    // Clear coinciding with an overflow capture: set wins
    applyStimulus(4'd7, 4'd1, SEL_ADD, 1'b0);
    step(1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    checkOutput("ovf_set_wins", int'(ovf_sticky), 1);
    step(2);

    // Backpressure: fill the FIFO, stall a sixth command, then release
    rsp_ready = 1'b0;
    rspCycles.delete();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    cmd_a = 4'd9;
    cmd_b = 4'd4;
    cmd_sel = SEL_XOR;
    cmd_use_acc = 1'b1;
    cmd_valid = 1'b1;
    step(2);
    checkOutput("bp_count_full", int'(fifo_count), 4);
    checkOutput("bp_ready_low", int'(cmd_ready), 0);
    rsp_ready = 1'b1;
    step(1);
    checkOutput("bp_count_pop_only", int'(fifo_count), 3);
    checkOutput("bp_ready_back", int'(cmd_ready), 1);
    step(1);
    checkOutput("bp_count_refill", int'(fifo_count), 4);
    cmd_valid = 1'b0;
    n = 0;
    while (rspCycles.size() < 6 && n < 60) begin
      step(1);
      n++;
    end
    checkOutput("bp_rsp_count", rspCycles.size(), 6);
    for (int i = 1; i < rspCycles.size(); i++) begin
      checkOutput("bp_rsp_spacing", rspCycles[i] - rspCycles[i-1], 2);
    end
    step(2);

    // Asynchronous reset during ISSUE with three commands queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 1'b0);
    end
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    checkOutput("mid_count_before", int'(fifo_count), 3);
    #2;
    rst_n = 1'b0;
    expQ.delete();
    accModel = '0;
    #1;
    checkOutput("mid_alu_a", int'(alu_a), 0);
    checkOutput("mid_alu_b", int'(alu_b), 0);
    checkOutput("mid_alu_sel", int'(alu_sel), 0);
    checkOutput("mid_rsp_y", int'(rsp_y), 0);
    checkOutput("mid_rsp_flags", int'(rsp_flags), 0);
    checkOutput("mid_rsp_valid", int'(rsp_valid), 0);
    checkOutput("mid_fifo_count", int'(fifo_count), 0);
    checkOutput("mid_ovf", int'(ovf_sticky), 0);
    checkOutput("mid_cmd_ready", int'(cmd_ready), 1);
    step(1);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    step(12);
    checkOutput("post_rst_no_rsp", int'(rsp_valid), 0);
    checkOutput("post_rst_count", int'(fifo_count), 0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      accepted = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      if (!cmd_valid || accepted) begin
        cmd_valid = ($urandom_range(0, 2) != 0);
        cmd_a = 4'($urandom_range(0, 15));
        cmd_b = 4'($urandom_range(0, 15));
        cmd_sel = 3'($urandom_range(0, 7));
        cmd_use_acc = 1'($urandom_range(0, 1));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (expQ.size() > 0 && n < 100) begin
      step(1);
      n++;
    end
    checkOutput("drain_left", expQ.size(), 0);
    step(2);
    checkOutput("end_rsp_valid", int'(rsp_valid), 0);
    checkOutput("end_fifo_count", int'(fifo_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
